// File: rtl/phase_sequencer_pkg.sv
// Shared constants and types for the five-phase instruction sequencer.
// Phase codes, state enum, opcode constants and instruction-class helpers.
package phase_sequencer_pkg;

    localparam logic [2:0] P1 = 3'b000;
    localparam logic [2:0] P2 = 3'b001;
    localparam logic [2:0] P3 = 3'b010;
    localparam logic [2:0] P4 = 3'b011;
    localparam logic [2:0] P5 = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    localparam logic [1:0] OP1_LD  = 2'b00;
    localparam logic [1:0] OP1_ST  = 2'b01;
    localparam logic [1:0] OP1_ALU = 2'b11;
    localparam logic [3:0] OP3_HLT = 4'b1111;

    function automatic logic is_mem_op(input logic [1:0] op1);
        return (op1 == OP1_LD) || (op1 == OP1_ST);
    endfunction

    function automatic logic is_halt_op(input logic [1:0] op1, input logic [3:0] op3);
        return (op1 == OP1_ALU) && (op3 == OP3_HLT);
    endfunction

endpackage

// File: rtl/phase_decode.sv
// Strobe generation for the sequencer: pure decode of registered state and
// phase together with the opcode fields held in the IR.
module phase_decode
    import phase_sequencer_pkg::*;
(
    input  state_t     state,
    input  logic [2:0] phase,
    input  logic [1:0] op1,
    input  logic [3:0] op3,
    input  logic       write_order,
    output logic       ir_we,
    output logic       mem_req,
    output logic       mem_we,
    output logic       reg_we,
    output logic       pc_we
);

    logic run;
    logic halt_op;

    assign run     = (state == RUN);
    assign halt_op = is_halt_op(op1, op3);

    assign ir_we   = run && (phase == P1);
    assign mem_req = run && (phase == P4) && is_mem_op(op1);
    assign mem_we  = mem_req && (op1 == OP1_ST);
    // A HLT retires without touching the register file or the PC.
    assign reg_we  = run && (phase == P5) && write_order && !halt_op;
    assign pc_we   = run && (phase == P5) && !halt_op;

endmodule

// File: rtl/phase_sequencer.sv
// Five-phase instruction sequencer (IF, ID, EX, MEM, WB) with start/stop and HLT.
// Optional retired-instruction counter enabled by PHASE_SEQ_INSTR_COUNT_EN.
module phase_sequencer
    import phase_sequencer_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        exec,
    input  logic [1:0]  op1,
    input  logic [3:0]  op3,
    input  logic        write_order,
    input  logic        mem_ready,
    output logic [2:0]  phase,
    output logic        running,
    output logic        halted,
    output logic        ir_we,
    output logic        mem_req,
    output logic        mem_we,
    output logic        reg_we,
    output logic        pc_we,
    output logic [15:0] instr_count
);

    state_t state;
    logic   stop_pending;
    logic   mem_op;
    logic   halt_op;

    assign mem_op  = is_mem_op(op1);
    assign halt_op = is_halt_op(op1, op3);

    // Memory handshake: mem_req stays high through every P4 cycle of a memory
    // instruction; the access completes on the first cycle mem_ready is also
    // high, and P5 follows on the next edge. mem_ready is ignored otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            phase        <= P1;
            stop_pending <= 1'b0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (exec) begin
                        state <= RUN;
                        phase <= P1;
                    end
                end
                RUN: begin
                    case (phase)
                        P1, P2, P3: begin
                            phase <= phase + 3'd1;
                            if (exec) stop_pending <= 1'b1;
                        end
                        P4: begin
                            if (!mem_op || mem_ready) phase <= P5;
                            if (exec) stop_pending <= 1'b1;
                        end
                        P5: begin
                            phase <= P1;
                            if (halt_op) begin
                                state        <= HALT;
                                stop_pending <= 1'b0;
                            end else if (stop_pending || exec) begin
                                state        <= IDLE;
                                stop_pending <= 1'b0;
                            end
                        end
                        default: phase <= P1;
                    endcase
                end
                default: begin
                    state        <= IDLE;
                    phase        <= P1;
                    stop_pending <= 1'b0;
                end
            endcase
        end
    end

    assign running = (state == RUN);
    assign halted  = (state == HALT);

    phase_decode u_decode (
        .state       (state),
        .phase       (phase),
        .op1         (op1),
        .op3         (op3),
        .write_order (write_order),
        .ir_we       (ir_we),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .reg_we      (reg_we),
        .pc_we       (pc_we)
    );

`ifdef PHASE_SEQ_INSTR_COUNT_EN
    logic [15:0] count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= 16'h0000;
        end else if ((state == RUN) && (phase == P5)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign instr_count = count_q;
`else
    assign instr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: directed scenarios with literal
// expectations, then randomized traffic against a cycle-level behavioural model.
module tb_phase_sequencer;

`ifdef PHASE_SEQ_INSTR_COUNT_EN
    localparam bit COUNT_EN = 1'b1;
`else
    localparam bit COUNT_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        exec;
    logic [1:0]  op1;
    logic [3:0]  op3;
    logic        write_order;
    logic        mem_ready;
    logic [2:0]  phase;
    logic        running;
    logic        halted;
    logic        ir_we;
    logic        mem_req;
    logic        mem_we;
    logic        reg_we;
    logic        pc_we;
    logic [15:0] instr_count;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Behavioural model: mode 0 idle, 1 run, 2 halt; phase as an integer 0..4.
    int m_mode  = 0;
    int m_phase = 0;
    int m_count = 0;
    bit m_stop  = 1'b0;

    logic [25:0] exp_q[$];

    always #5 clock = ~clock;

    phase_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .exec        (exec),
        .op1         (op1),
        .op3         (op3),
        .write_order (write_order),
        .mem_ready   (mem_ready),
        .phase       (phase),
        .running     (running),
        .halted      (halted),
        .ir_we       (ir_we),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .reg_we      (reg_we),
        .pc_we       (pc_we),
        .instr_count (instr_count)
    );

    function automatic bit model_is_mem();
        return (op1 == 2'b00) || (op1 == 2'b01);
    endfunction

    function automatic bit model_is_hlt();
        return (op1 == 2'b11) && (op3 == 4'hF);
    endfunction

    always @(posedge clock) begin : model
        if (reset) begin
            m_mode  = 0;
            m_phase = 0;
            m_stop  = 1'b0;
            m_count = 0;
        end else if (m_mode != 1) begin
            if (exec) begin
                m_mode  = 1;
                m_phase = 0;
            end
        end else if (m_phase == 4) begin
            if (COUNT_EN) m_count = (m_count + 1) % 65536;
            if (model_is_hlt()) begin
                m_mode = 2;
                m_stop = 1'b0;
            end else if (m_stop || exec) begin
                m_mode = 0;
                m_stop = 1'b0;
            end
            m_phase = 0;
        end else begin
            if (exec) m_stop = 1'b1;
            if (!(m_phase == 3 && model_is_mem() && !mem_ready)) m_phase = m_phase + 1;
        end
    end

    function automatic logic [25:0] model_out();
        logic       run;
        logic [2:0] ph;
        logic       mreq;
        run  = (m_mode == 1);
        ph   = 3'(m_phase);
        mreq = run && (m_phase == 3) && model_is_mem();
        return {ph, run, (m_mode == 2) ? 1'b1 : 1'b0,
                run && (m_phase == 0),
                mreq,
                mreq && (op1 == 2'b01),
                run && (m_phase == 4) && write_order && !model_is_hlt(),
                run && (m_phase == 4) && !model_is_hlt(),
                16'(m_count)};
    endfunction

    always @(negedge clock) begin : compare
        logic [25:0] exp_v;
        logic [25:0] got_v;
        if (chk_en) begin
            exp_q.push_back(model_out());
            exp_v = exp_q.pop_front();
            got_v = {phase, running, halted, ir_we, mem_req, mem_we, reg_we, pc_we, instr_count};
            n_checks++;
            if (got_v !== exp_v) begin
                n_errors++;
                $display("FAIL model_cycle t=%0t got=%h expected=%h", $time, got_v, exp_v);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_strobes_zero(input string name);
        check(name, {27'd0, ir_we, mem_req, mem_we, reg_we, pc_we}, 32'd0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic [14:0] seq;
        logic [4:0]  rw;
        logic [4:0]  pw;
        int cycles, mq, mw, np4, st_rw, st_pw;

        reset = 1'b1; exec = 1'b0; op1 = 2'b11; op3 = 4'h0;
        write_order = 1'b0; mem_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        chk_en = 1'b1;
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check_strobes_zero("rst_strobes");
        check("rst_count", 32'(instr_count), 32'd0);
        step();
        check("idle_hold_phase", 32'(phase), 32'd0);
        check_strobes_zero("idle_strobes");

        // ADD: five cycles, write strobes only in P5
        op1 = 2'b11; op3 = 4'h0; write_order = 1'b1;
        exec = 1'b1; step(); exec = 1'b0;
        check("exec_running", 32'(running), 32'd1);
        check("exec_ir_we", 32'(ir_we), 32'd1);
        seq = '0; rw = '0; pw = '0;
        for (int i = 0; i < 5; i++) begin
            seq   = {seq[11:0], phase};
            rw[i] = reg_we;
            pw[i] = pc_we;
            step();
        end
        check("add_phases", 32'(seq), 32'(15'b000_001_010_011_100));
        check("add_reg_we", 32'(rw), 32'(5'b10000));
        check("add_pc_we", 32'(pw), 32'(5'b10000));
        check("add_next_phase", 32'(phase), 32'd0);
        check("add_count", 32'(instr_count), COUNT_EN ? 32'd1 : 32'd0);

        // LD with three not-ready P4 cycles
        op1 = 2'b00;
        cycles = 0; mq = 0; mw = 0; np4 = 0;
        do begin
            if (phase == 3'd3) begin
                mem_ready = (np4 >= 3);
                np4++;
                mq += int'(mem_req);
                mw += int'(mem_we);
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            step();
            cycles++;
        end while (phase != 3'd0 && cycles < 30);
        check("ld_cycles", 32'(cycles), 32'd8);
        check("ld_mem_req_cycles", 32'(mq), 32'd4);
        check("ld_mem_we_cycles", 32'(mw), 32'd0);
        check("ld_count", 32'(instr_count), COUNT_EN ? 32'd2 : 32'd0);

        // ST without register write
        op1 = 2'b01; write_order = 1'b0; mem_ready = 1'b1;
        cycles = 0; mw = 0; st_rw = 0; st_pw = 0;
        do begin
            if (phase == 3'd3) mw += int'(mem_we);
            if (phase == 3'd4) begin
                st_rw += int'(reg_we);
                st_pw += int'(pc_we);
            end
            step();
            cycles++;
        end while (phase != 3'd0 && cycles < 30);
        check("st_cycles", 32'(cycles), 32'd5);
        check("st_mem_we", 32'(mw), 32'd1);
        check("st_reg_we", 32'(st_rw), 32'd0);
        check("st_pc_we", 32'(st_pw), 32'd1);

        // HLT with exec in its P5: halt wins over stop
        op1 = 2'b11; op3 = 4'hF; write_order = 1'b1;
        cycles = 0; st_rw = 0; st_pw = 0;
        do begin
            if (phase == 3'd4) begin
                st_rw += int'(reg_we);
                st_pw += int'(pc_we);
                exec = 1'b1;
            end
            step();
            exec = 1'b0;
            cycles++;
        end while (phase != 3'd0 && cycles < 30);
        check("hlt_cycles", 32'(cycles), 32'd5);
        check("hlt_reg_we", 32'(st_rw), 32'd0);
        check("hlt_pc_we", 32'(st_pw), 32'd0);
        check("hlt_halted", 32'(halted), 32'd1);
        check("hlt_running", 32'(running), 32'd0);
        check("hlt_count", 32'(instr_count), COUNT_EN ? 32'd4 : 32'd0);
        for (int i = 0; i < 6; i++) begin
            op1 = 2'($urandom_range(0, 3));
            op3 = 4'($urandom_range(0, 15));
            write_order = 1'($urandom_range(0, 1));
            mem_ready = 1'($urandom_range(0, 1));
            step();
            check("halt_hold", 32'({halted, phase}), 32'(4'b1000));
            check_strobes_zero("halt_strobes");
        end
        op1 = 2'b11; op3 = 4'h0; write_order = 1'b1;
        exec = 1'b1; step(); exec = 1'b0;
        check("resume_running", 32'(running), 32'd1);
        check("resume_phase", 32'(phase), 32'd0);
        check("resume_ir_we", 32'(ir_we), 32'd1);

        // Stop requested in P2 (and again in P3): finish through P5, then IDLE
        step();
        exec = 1'b1; step(); exec = 1'b0;
        exec = 1'b1; step(); exec = 1'b0;
        step();
        check("stop_p5_phase", 32'(phase), 32'd4);
        check("stop_p5_running", 32'(running), 32'd1);
        step();
        check("stop_idle", 32'({running, halted, phase}), 32'd0);
        step();
        check("stop_idle_hold", 32'({running, phase}), 32'd0);

        // Reset during a P4 memory wait
        op1 = 2'b00; mem_ready = 1'b0;
        exec = 1'b1; step(); exec = 1'b0;
        step(); step(); step(); step();
        check("wait_phase", 32'(phase), 32'd3);
        check("wait_mem_req", 32'(mem_req), 32'd1);
        reset = 1'b1; step(); reset = 1'b0;
        check("rst_wait_phase", 32'(phase), 32'd0);
        check("rst_wait_running", 32'(running), 32'd0);
        check_strobes_zero("rst_wait_strobes");
        check("rst_wait_count", 32'(instr_count), 32'd0);

        // Randomized traffic; opcodes only change outside P2..P5
        for (int c = 0; c < 3000; c++) begin
            if (m_mode != 1 || m_phase == 0) begin
                op1 = 2'($urandom_range(0, 3));
                op3 = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
                write_order = 1'($urandom_range(0, 1));
            end
            exec      = ($urandom_range(0, 15) == 0);
            mem_ready = ($urandom_range(0, 2) != 0);
            reset     = ($urandom_range(0, 299) == 0);
            step();
        end
        exec = 1'b0; reset = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
